// File: rtl/distance_filter_pkg.sv
// Shared constants and state encoding for the ultrasonic distance conditioning path.
// The sensor front end and the slicing controller both use DIST_W.
package distance_filter_pkg;

  localparam int DIST_W = 17;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1
  } state_e;

  localparam logic [DIST_W-1:0] MAX_DIST_DEF    = 17'd23200;
  localparam logic [DIST_W-1:0] TOL_DEF         = 17'd58;
  localparam int                STABLE_CNT_DEF  = 3;
  localparam logic [23:0]       TIMEOUT_CYC_DEF = 24'd3000000;

endpackage

// File: rtl/distance_filter_if.sv
// Sample/result bundle between the ranging block, the filter and the slicing controller.
interface distance_filter_if;
  import distance_filter_pkg::*;

  logic              valid_i;
  logic [DIST_W-1:0] distance_i;
  logic              flush_i;
  logic              valid_o;
  logic [DIST_W-1:0] distance_o;
  logic              stable_o;
  logic              reject_o;
  logic              timeout_o;

  modport master (
    output valid_i, distance_i, flush_i,
    input  valid_o, distance_o, stable_o, reject_o, timeout_o
  );

  modport slave (
    input  valid_i, distance_i, flush_i,
    output valid_o, distance_o, stable_o, reject_o, timeout_o
  );

endinterface

// File: rtl/distance_filter_sample_window.sv
// Ring buffer of the last 2^LOG_DEPTH accepted samples with a running sum and average.
module sample_window
  import distance_filter_pkg::*;
#(
  parameter int LOG_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              wr_i,
  input  logic [DIST_W-1:0] din_i,
  output logic [DIST_W-1:0] avg_o,
  output logic              full_o
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int SUM_W = DIST_W + LOG_DEPTH;

  logic [DIST_W-1:0]    buf_q [DEPTH];
  logic [LOG_DEPTH-1:0] ptr_q;
  logic [LOG_DEPTH:0]   fill_q;
  logic [SUM_W-1:0]     sum_q;
  logic [SUM_W-1:0]     sum_d;
  logic [DIST_W-1:0]    old_w;
  logic                 at_depth;

  // Stale entries left behind by a flush must not be subtracted while refilling.
  assign at_depth = (fill_q == (LOG_DEPTH + 1)'(DEPTH));
  assign old_w    = at_depth ? buf_q[ptr_q] : '0;
  assign sum_d    = sum_q + SUM_W'(din_i) - SUM_W'(old_w);
  assign avg_o    = DIST_W'(sum_d >> LOG_DEPTH);
  // Window holds DEPTH samples once the current write lands.
  assign full_o   = (fill_q >= (LOG_DEPTH + 1)'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      ptr_q  <= '0;
      fill_q <= '0;
      sum_q  <= '0;
    end else if (flush_i) begin
      ptr_q  <= '0;
      fill_q <= '0;
      sum_q  <= '0;
    end else if (wr_i) begin
      buf_q[ptr_q] <= din_i;
      ptr_q        <= ptr_q + 1'b1;
      sum_q        <= sum_d;
      if (!at_depth) fill_q <= fill_q + 1'b1;
    end
  end

endmodule

// File: rtl/distance_filter.sv
// Range-gates raw echoes, averages them over a sliding window and reports
// stability and sensor silence to the slicing controller.
module distance_filter
  import distance_filter_pkg::*;
#(
  parameter int                LOG_DEPTH   = 2,
  parameter logic [DIST_W-1:0] MAX_DIST    = MAX_DIST_DEF,
  parameter logic [DIST_W-1:0] TOL         = TOL_DEF,
  parameter int                STABLE_CNT  = STABLE_CNT_DEF,
  parameter logic [23:0]       TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic              clk,
  input logic              rst,
  distance_filter_if.slave bus
);

  localparam int SC_W = $clog2(STABLE_CNT + 1);

  function automatic logic [DIST_W-1:0] abs_diff(input logic [DIST_W-1:0] a,
                                                 input logic [DIST_W-1:0] b);
    logic signed [DIST_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? DIST_W'(-d) : DIST_W'(d);
  endfunction

  function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] c);
    return (c == SC_W'(STABLE_CNT)) ? c : c + 1'b1;
  endfunction

  state_e            state_q;
  logic              valid_q;
  logic [DIST_W-1:0] dist_q;
  logic              stable_q;
  logic              reject_q;
  logic              timeout_q;
  logic [SC_W-1:0]   stab_q;
  logic [SC_W-1:0]   stab_d;
  logic [DIST_W-1:0] prev_q;
  logic              have_prev_q;
  logic [23:0]       tmo_q;

  logic              acc;
  logic              expire;
  logic              flush;
  logic              take;
  logic              fire;
  logic [DIST_W-1:0] avg;
  logic              full;

  assign acc    = bus.valid_i && (bus.distance_i != '0) && (bus.distance_i <= MAX_DIST);
  // A sample arriving on the expiry cycle proves the sensor is alive, so it wins.
  assign expire = (tmo_q == TIMEOUT_CYC - 24'd1) && !acc;
  assign flush  = bus.flush_i || expire;
  assign take   = acc && !flush;
  assign fire   = take && full;

  sample_window #(
    .LOG_DEPTH (LOG_DEPTH)
  ) u_window (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .wr_i    (take),
    .din_i   (bus.distance_i),
    .avg_o   (avg),
    .full_o  (full)
  );

  always_comb begin
    stab_d = stab_q;
    if (!have_prev_q)                 stab_d = '0;
    else if (abs_diff(avg, prev_q) <= TOL) stab_d = sat_inc(stab_q);
    else                              stab_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      valid_q     <= 1'b0;
      dist_q      <= '0;
      stable_q    <= 1'b0;
      reject_q    <= 1'b0;
      timeout_q   <= 1'b0;
      stab_q      <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      valid_q  <= 1'b0;
      reject_q <= bus.valid_i && !acc;
      tmo_q    <= (acc || expire) ? 24'd0 : tmo_q + 24'd1;
      if (flush) begin
        state_q     <= FILL;
        stab_q      <= '0;
        prev_q      <= '0;
        have_prev_q <= 1'b0;
        stable_q    <= 1'b0;
        if (expire) timeout_q <= 1'b1;
      end else if (take) begin
        timeout_q <= 1'b0;
        if (fire) begin
          if (state_q == FILL) state_q <= RUN;
          valid_q     <= 1'b1;
          dist_q      <= avg;
          stab_q      <= stab_d;
          prev_q      <= avg;
          have_prev_q <= 1'b1;
          stable_q    <= (stab_d == SC_W'(STABLE_CNT));
        end
      end
    end
  end

  assign bus.valid_o    = valid_q;
  assign bus.distance_o = dist_q;
  assign bus.stable_o   = stable_q;
  assign bus.reject_o   = reject_q;
  assign bus.timeout_o  = timeout_q;

endmodule
